// File: rtl/packet_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | packet_filter_pkg: frame_checker register map, bit indices, states.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package packet_filter_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'd0;
  localparam logic [7:0] ADDR_IFG    = 8'd1;
  localparam logic [7:0] ADDR_STATUS = 8'd2;
  localparam logic [7:0] ADDR_CSUM0  = 8'd4;
  localparam logic [7:0] ADDR_CSUM1  = 8'd5;
  localparam logic [7:0] ADDR_CSUM2  = 8'd6;
  localparam logic [7:0] ADDR_CSUM3  = 8'd7;
  localparam logic [7:0] ADDR_BEATS0 = 8'd8;
  localparam logic [7:0] ADDR_BEATS1 = 8'd9;
  localparam logic [7:0] ADDR_FCNT0  = 8'd10;
  localparam logic [7:0] ADDR_FCNT1  = 8'd11;
  localparam logic [7:0] ADDR_OCNT0  = 8'd12;
  localparam logic [7:0] ADDR_OCNT1  = 8'd13;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLR    = 1;

  localparam int STATUS_RECV = 0;
  localparam int STATUS_WAIT = 1;
  localparam int STATUS_DONE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    WAIT = 2'd2
  } frame_checker_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_checker_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_checker_regs: Avalon-MM decode, CTRL/IFG registers, read mux   |
// | and high-byte snapshot shadows. Macro: FRAME_CHECKER_OVERSIZE_EN.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module frame_checker_regs
  import packet_filter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       writedata,
  input  logic             write,
  input  logic             chipselect,
  input  logic [7:0]       address,
  input  logic             read,
  output logic [7:0]       readdata,
  output logic             enable,
  output logic             clr,
  output logic [7:0]       ifg_wait,
  input  logic [2:0]       status,
  input  logic [31:0]      last_csum,
  input  logic [CNT_W-1:0] last_beats,
  input  logic [CNT_W-1:0] frame_cnt
`ifdef FRAME_CHECKER_OVERSIZE_EN
  ,
  input  logic [CNT_W-1:0] oversize_cnt
`endif
);

  logic        wr_en;
  logic        rd_en;
  logic [15:0] beats16;
  logic [15:0] fcnt16;
  logic [23:0] csum_shadow;
  logic [7:0]  beats_shadow;
  logic [7:0]  fcnt_shadow;
  logic [7:0]  rd_mux;

  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign clr     = wr_en && (address == ADDR_CTRL) && writedata[CTRL_CLR];
  assign beats16 = 16'(last_beats);
  assign fcnt16  = 16'(frame_cnt);

`ifdef FRAME_CHECKER_OVERSIZE_EN
  logic [15:0] ocnt16;
  logic [7:0]  ocnt_shadow;
  assign ocnt16 = 16'(oversize_cnt);
`endif

  // Upper bytes of multi-byte values come from shadows captured by the low-byte read.
  always_comb begin
    rd_mux = 8'd0;
    case (address)
      ADDR_CTRL:   rd_mux = {7'd0, enable};
      ADDR_IFG:    rd_mux = ifg_wait;
      ADDR_STATUS: rd_mux = {5'd0, status};
      ADDR_CSUM0:  rd_mux = last_csum[7:0];
      ADDR_CSUM1:  rd_mux = csum_shadow[7:0];
      ADDR_CSUM2:  rd_mux = csum_shadow[15:8];
      ADDR_CSUM3:  rd_mux = csum_shadow[23:16];
      ADDR_BEATS0: rd_mux = beats16[7:0];
      ADDR_BEATS1: rd_mux = beats_shadow;
      ADDR_FCNT0:  rd_mux = fcnt16[7:0];
      ADDR_FCNT1:  rd_mux = fcnt_shadow;
`ifdef FRAME_CHECKER_OVERSIZE_EN
      ADDR_OCNT0:  rd_mux = ocnt16[7:0];
      ADDR_OCNT1:  rd_mux = ocnt_shadow;
`endif
      default:     rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable       <= 1'b0;
      ifg_wait     <= 8'd0;
      readdata     <= 8'd0;
      csum_shadow  <= 24'd0;
      beats_shadow <= 8'd0;
      fcnt_shadow  <= 8'd0;
    end else begin
      if (wr_en && (address == ADDR_CTRL)) enable <= writedata[CTRL_ENABLE];
      if (wr_en && (address == ADDR_IFG))  ifg_wait <= writedata;
      readdata <= rd_en ? rd_mux : 8'd0;
      if (rd_en && (address == ADDR_CSUM0))  csum_shadow  <= last_csum[31:8];
      if (rd_en && (address == ADDR_BEATS0)) beats_shadow <= beats16[15:8];
      if (rd_en && (address == ADDR_FCNT0))  fcnt_shadow  <= fcnt16[15:8];
    end
  end

`ifdef FRAME_CHECKER_OVERSIZE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ocnt_shadow <= 8'd0;
    end else if (rd_en && (address == ADDR_OCNT0)) begin
      ocnt_shadow <= ocnt16[15:8];
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_checker: AXI-stream sink with inter-frame gap, checksum and    |
// | frame statistics. Macro: FRAME_CHECKER_OVERSIZE_EN. Rev 1.0          |
// +----------------------------------------------------------------------+
module frame_checker
  import packet_filter_pkg::*;
#(
  parameter int TDATA_W   = 16,
  parameter int MAX_BEATS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         writedata,
  input  logic               write,
  input  logic               chipselect,
  input  logic [7:0]         address,
  input  logic               read,
  output logic [7:0]         readdata,
  input  logic [TDATA_W-1:0] ingress_port_tdata,
  input  logic               ingress_port_tvalid,
  output logic               ingress_port_tready,
  input  logic               ingress_port_tlast
);

  localparam logic [CNT_W-1:0] BEATS_SAT = '1;
  localparam logic [CNT_W-1:0] ONE_BEAT  = {{(CNT_W-1){1'b0}}, 1'b1};

  frame_checker_state_t state;
  logic [7:0]           gap_cnt;
  logic [31:0]          csum;
  logic [CNT_W-1:0]     beats;
  logic [31:0]          last_csum;
  logic [CNT_W-1:0]     last_beats;
  logic [CNT_W-1:0]     frame_cnt;
  logic                 done;
  logic                 enable;
  logic                 clr;
  logic [7:0]           ifg_wait;
  logic [2:0]           status;
  logic                 accept;
  logic                 frame_end;
  logic                 first;
  logic [31:0]          csum_next;
  logic [CNT_W-1:0]     beats_next;

  // A started frame always completes, so RECV ignores ENABLE.
  assign ingress_port_tready = (state == RECV) || ((state == IDLE) && enable);
  assign accept     = ingress_port_tvalid && ingress_port_tready;
  assign frame_end  = accept && ingress_port_tlast;
  assign first      = (state == IDLE);
  assign csum_next  = first ? 32'(ingress_port_tdata) : csum + 32'(ingress_port_tdata);
  assign beats_next = first ? ONE_BEAT : ((beats == BEATS_SAT) ? beats : beats + ONE_BEAT);

  always_comb begin
    status              = 3'd0;
    status[STATUS_RECV] = (state == RECV);
    status[STATUS_WAIT] = (state == WAIT);
    status[STATUS_DONE] = done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gap_cnt    <= 8'd0;
      csum       <= 32'd0;
      beats      <= '0;
      last_csum  <= 32'd0;
      last_beats <= '0;
    end else begin
      case (state)
        IDLE, RECV: begin
          if (accept) begin
            csum  <= csum_next;
            beats <= beats_next;
            if (ingress_port_tlast) begin
              last_csum  <= csum_next;
              last_beats <= beats_next;
              if (ifg_wait == 8'd0) begin
                state <= IDLE;
              end else begin
                state   <= WAIT;
                gap_cnt <= ifg_wait;
              end
            end else begin
              state <= RECV;
            end
          end
        end
        WAIT: begin
          if (gap_cnt == 8'd1) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // CLR is applied after the frame-end update so it wins on a coincident edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      done      <= 1'b0;
    end else begin
      if (frame_end) begin
        frame_cnt <= frame_cnt + ONE_BEAT;
        done      <= 1'b1;
      end
      if (clr) begin
        frame_cnt <= '0;
        done      <= 1'b0;
      end
    end
  end

`ifdef FRAME_CHECKER_OVERSIZE_EN
  localparam logic [31:0] MAX_BEATS_W = 32'(MAX_BEATS);
  logic [CNT_W-1:0] oversize_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      oversize_cnt <= '0;
    end else begin
      if (frame_end && (32'(beats_next) > MAX_BEATS_W) && (oversize_cnt != BEATS_SAT))
        oversize_cnt <= oversize_cnt + ONE_BEAT;
      if (clr)
        oversize_cnt <= '0;
    end
  end
`endif

  frame_checker_regs #(
    .CNT_W(CNT_W)
  ) u_regs (
    .clk          (clk),
    .reset        (reset),
    .writedata    (writedata),
    .write        (write),
    .chipselect   (chipselect),
    .address      (address),
    .read         (read),
    .readdata     (readdata),
    .enable       (enable),
    .clr          (clr),
    .ifg_wait     (ifg_wait),
    .status       (status),
    .last_csum    (last_csum),
    .last_beats   (last_beats),
    .frame_cnt    (frame_cnt)
`ifdef FRAME_CHECKER_OVERSIZE_EN
    ,
    .oversize_cnt (oversize_cnt)
`endif
  );

endmodule
`default_nettype wire

// File: tb/tb_frame_checker.sv
`default_nettype none
// tb_frame_checker: directed plan plus randomized traffic, checked every cycle
// against a frame-level model of the register map and stream flow control.
`timescale 1ns/1ps
module tb_frame_checker;

  localparam int TDATA_W   = 16;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         writedata = 8'd0;
  logic               write = 1'b0;
  logic               chipselect = 1'b0;
  logic [7:0]         address = 8'd0;
  logic               read = 1'b0;
  logic [7:0]         readdata;
  logic [TDATA_W-1:0] tdata = '0;
  logic               tvalid = 1'b0;
  logic               tready;
  logic               tlast = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  frame_checker #(
    .TDATA_W   (TDATA_W),
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .writedata           (writedata),
    .write               (write),
    .chipselect          (chipselect),
    .address             (address),
    .read                (read),
    .readdata            (readdata),
    .ingress_port_tdata  (tdata),
    .ingress_port_tvalid (tvalid),
    .ingress_port_tready (tready),
    .ingress_port_tlast  (tlast)
  );

  // ---------------- frame-level reference model ----------------
  bit          m_valid = 0;
  bit          m_enable, m_in_frame, m_done, m_tready;
  int          m_gap, m_beats;
  logic [7:0]  m_ifg, m_rd;
  logic [31:0] m_sum, m_last_csum;
  logic [15:0] m_last_beats, m_frame_cnt, m_over_cnt;
  logic [23:0] m_sh_csum;
  logic [7:0]  m_sh_beats, m_sh_fcnt, m_sh_ocnt;

  function automatic logic [7:0] model_byte(input logic [7:0] a);
    case (a)
      8'd0:  return {7'd0, m_enable};
      8'd1:  return m_ifg;
      8'd2:  return {5'd0, m_done, (m_gap > 0), m_in_frame};
      8'd4:  return m_last_csum[7:0];
      8'd5:  return m_sh_csum[7:0];
      8'd6:  return m_sh_csum[15:8];
      8'd7:  return m_sh_csum[23:16];
      8'd8:  return m_last_beats[7:0];
      8'd9:  return m_sh_beats;
      8'd10: return m_frame_cnt[7:0];
      8'd11: return m_sh_fcnt;
`ifdef FRAME_CHECKER_OVERSIZE_EN
      8'd12: return m_over_cnt[7:0];
      8'd13: return m_sh_ocnt;
`endif
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit         acc, rd, wr, clr;
    logic [7:0] old_ifg;
    if (reset) begin
      m_enable = 0; m_in_frame = 0; m_done = 0; m_gap = 0; m_beats = 0;
      m_ifg = 8'd0; m_rd = 8'd0; m_sum = 32'd0; m_last_csum = 32'd0;
      m_last_beats = 16'd0; m_frame_cnt = 16'd0; m_over_cnt = 16'd0;
      m_sh_csum = 24'd0; m_sh_beats = 8'd0; m_sh_fcnt = 8'd0; m_sh_ocnt = 8'd0;
      m_valid = 1;
    end else begin
      acc     = tvalid && m_tready;
      rd      = chipselect && read;
      wr      = chipselect && write;
      clr     = wr && (address == 8'd0) && writedata[1];
      old_ifg = m_ifg;
      m_rd    = rd ? model_byte(address) : 8'd0;
      if (rd && address == 8'd4)  m_sh_csum  = m_last_csum[31:8];
      if (rd && address == 8'd8)  m_sh_beats = m_last_beats[15:8];
      if (rd && address == 8'd10) m_sh_fcnt  = m_frame_cnt[15:8];
      if (rd && address == 8'd12) m_sh_ocnt  = m_over_cnt[15:8];
      if (m_gap > 0) begin
        m_gap--;
      end else if (acc) begin
        if (!m_in_frame) begin
          m_sum = 32'(tdata); m_beats = 1;
        end else begin
          m_sum = m_sum + 32'(tdata);
          if (m_beats < 65535) m_beats++;
        end
        if (tlast) begin
          m_last_csum  = m_sum;
          m_last_beats = 16'(m_beats);
          m_frame_cnt  = m_frame_cnt + 16'd1;
          m_done       = 1;
`ifdef FRAME_CHECKER_OVERSIZE_EN
          if (m_beats > MAX_BEATS && m_over_cnt != 16'hFFFF) m_over_cnt = m_over_cnt + 16'd1;
`endif
          m_in_frame = 0;
          m_gap      = int'(old_ifg);
        end else begin
          m_in_frame = 1;
        end
      end
      if (wr && address == 8'd0) m_enable = writedata[0];
      if (wr && address == 8'd1) m_ifg = writedata;
      if (clr) begin
        m_frame_cnt = 16'd0; m_over_cnt = 16'd0; m_done = 0;
      end
    end
    m_tready = m_in_frame || (m_gap == 0 && m_enable);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      compared++;
      if (tready !== m_tready) begin
        mismatched++;
        $display("FAIL tready @%0t: got %b expected %b", $time, tready, m_tready);
      end
      compared++;
      if (readdata !== m_rd) begin
        mismatched++;
        $display("FAIL readdata @%0t: got 0x%02h expected 0x%02h", $time, readdata, m_rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic avs_write(input logic [7:0] a, input logic [7:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    cyc();
    chipselect = 0; write = 0;
  endtask

  task automatic check_rd(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    chipselect = 1; read = 1; address = a;
    cyc();
    d = readdata;
    chipselect = 0; read = 0;
    check(name, 32'(d), 32'(exp));
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last);
    int n;
    bit acc;
    n = 0;
    tvalid = 1; tdata = d; tlast = last;
    do begin
      acc = tready;
      cyc();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic stop_stream();
    tvalid = 0; tlast = 0;
  endtask

  initial begin
    int low;
    int r;
    repeat (3) cyc();
    reset = 0;
    check("reset_tready", 32'(tready), 32'd0);
    check_rd("reset_ctrl", 8'd0, 8'd0);
    check_rd("reset_status", 8'd2, 8'd0);
    check_rd("reset_csum0", 8'd4, 8'd0);

    // 3-beat frame, no gap
    avs_write(8'd0, 8'd1);
    avs_write(8'd1, 8'd0);
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0002, 1'b0);
    send_beat(16'hFFFF, 1'b1);
    stop_stream();
    check_rd("csum_b0", 8'd4, 8'h02);
    check_rd("csum_b1", 8'd5, 8'h00);
    check_rd("csum_b2", 8'd6, 8'h01);
    check_rd("csum_b3", 8'd7, 8'h00);
    check_rd("beats_lo", 8'd8, 8'd3);
    check_rd("fcnt_1", 8'd10, 8'd1);
    check_rd("status_done", 8'd2, 8'h04);

    // inter-frame gap of 4 with tvalid held high
    avs_write(8'd0, 8'd3);
    avs_write(8'd1, 8'd4);
    send_beat(16'h0005, 1'b1);
    low = 0;
    while (!tready && low < 50) begin
      low++;
      cyc();
    end
    check("ifg_low_cycles", 32'(low), 32'd4);
    send_beat(16'h0006, 1'b1);
    stop_stream();
    repeat (6) cyc();
    check_rd("fcnt_2", 8'd10, 8'd2);

    // ENABLE cleared mid-frame
    avs_write(8'd1, 8'd0);
    send_beat(16'h0010, 1'b0);
    stop_stream();
    avs_write(8'd0, 8'd0);
    check("recv_ignores_enable", 32'(tready), 32'd1);
    send_beat(16'h0020, 1'b1);
    stop_stream();
    tvalid = 1; tdata = 16'h0030; tlast = 1;
    repeat (5) cyc();
    check("disabled_tready", 32'(tready), 32'd0);
    check_rd("fcnt_disabled", 8'd10, 8'd3);
    avs_write(8'd0, 8'd1);
    cyc();
    stop_stream();
    check_rd("fcnt_reenabled", 8'd10, 8'd4);
    check_rd("csum_reenabled", 8'd4, 8'h30);

    // oversize frame (5 beats > MAX_BEATS=4)
    for (int i = 1; i <= 5; i++) send_beat(16'(i), i == 5);
    stop_stream();
    check_rd("beats_5", 8'd8, 8'd5);
`ifdef FRAME_CHECKER_OVERSIZE_EN
    check_rd("oversize_1", 8'd12, 8'd1);
`else
    check_rd("oversize_absent", 8'd12, 8'd0);
`endif

    // coherent multi-byte checksum read
    check_rd("snap_csum0", 8'd4, 8'h0F);
    send_beat(16'h1234, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h0101, 1'b1);
    stop_stream();
    check_rd("old_csum_b1", 8'd5, 8'h00);
    check_rd("old_csum_b2", 8'd6, 8'h00);
    check_rd("old_csum_b3", 8'd7, 8'h00);
    check_rd("new_csum_b0", 8'd4, 8'h34);
    check_rd("new_csum_b1", 8'd5, 8'h13);
    check_rd("new_csum_b2", 8'd6, 8'h01);

    // CLR coincident with a tlast beat
    tvalid = 1; tdata = 16'h00AB; tlast = 1;
    chipselect = 1; write = 1; address = 8'd0; writedata = 8'h03;
    cyc();
    chipselect = 0; write = 0;
    stop_stream();
    check_rd("clr_fcnt", 8'd10, 8'd0);
    check_rd("clr_status", 8'd2, 8'd0);
    check_rd("clr_csum_updated", 8'd4, 8'hAB);
    check_rd("clr_beats_updated", 8'd8, 8'd1);

    // reset mid-frame
    send_beat(16'h0007, 1'b0);
    stop_stream();
    reset = 1;
    cyc();
    reset = 0;
    check("rst_mid_tready", 32'(tready), 32'd0);
    for (int a = 0; a < 16; a++) check_rd("rst_mid_reg", 8'(a), 8'd0);

    // randomized traffic
    avs_write(8'd0, 8'd1);
    for (int i = 0; i < 4000; i++) begin
      tvalid = ($urandom_range(0, 3) != 0);
      tdata  = 16'($urandom);
      tlast  = ($urandom_range(0, 4) == 0);
      chipselect = 0; read = 0; write = 0;
      r = $urandom_range(0, 19);
      if (r < 4) begin
        chipselect = 1; read = 1; address = 8'($urandom_range(0, 15));
      end else if (r == 4) begin
        chipselect = 1; write = 1; address = 8'($urandom_range(0, 15));
        if (address == 8'd0)
          writedata = (($urandom_range(0, 9) == 0) ? 8'd2 : 8'd0) |
                      (($urandom_range(0, 7) != 0) ? 8'd1 : 8'd0);
        else if (address == 8'd1)
          writedata = 8'($urandom_range(0, 5));
        else
          writedata = 8'($urandom);
      end
      reset = (i % 997 == 500);
      cyc();
      if (reset) begin
        reset = 0;
        chipselect = 1; write = 1; address = 8'd0; writedata = 8'd1;
        cyc();
      end
    end
    chipselect = 0; read = 0; write = 0; reset = 0;
    stop_stream();
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
